// File: rtl/beam_thresh_loader.sv
// Threshold loader for the dual-beam DSP array: per-beam staged writes on a shared bus, then a
// common update strobe issued only after the last load strobe has drained.
module beam_thresh_loader #(
  parameter int unsigned NBEAMS    = 48,
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [17:0]          thresh_dat_i,
  input  logic [ADDR_BITS-1:0] thresh_addr_i,
  input  logic                 thresh_valid_i,
  output logic                 thresh_ready_o,
  input  logic                 commit_i,
  output logic [17:0]          thresh_o,
  output logic [NBEAMS-1:0]    thresh_ce_o,
  output logic                 update_o,
  output logic                 commit_done_o,
  output logic                 addr_err_o,
  output logic                 busy_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDrain  = 2'd1;
  localparam logic [1:0] StUpdate = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]        stateQ, stateD;
  logic [17:0]       threshQ, threshD;
  logic [NBEAMS-1:0] ceQ, ceD;
  logic              addrErrQ, addrErrD;
  logic              updateQ, doneQ, busyQ;
  logic              acceptWr, addrOk;
  logic [31:0]       addrWide;

  assign thresh_ready_o = (stateQ == StIdle) & ~rst_i;
  assign acceptWr       = thresh_valid_i & thresh_ready_o;
  assign addrWide       = 32'(thresh_addr_i);
  assign addrOk         = addrWide < NBEAMS;

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle:   if (commit_i) stateD = StDrain;
      StDrain:  stateD = StUpdate;
      StUpdate: stateD = StDone;
      StDone:   stateD = StIdle;
      default:  stateD = StIdle;
    endcase
  end

  // Load strobes last a single cycle; an out-of-range write only raises the error pulse.
  always_comb begin
    threshD  = threshQ;
    ceD      = '0;
    addrErrD = 1'b0;
    if (acceptWr) begin
      if (addrOk) begin
        threshD = thresh_dat_i;
        for (int unsigned b = 0; b < NBEAMS; b++) begin
          ceD[b] = (addrWide == b);
        end
      end else begin
        addrErrD = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stateQ   <= StIdle;
      threshQ  <= '0;
      ceQ      <= '0;
      addrErrQ <= 1'b0;
      updateQ  <= 1'b0;
      doneQ    <= 1'b0;
      busyQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      threshQ  <= threshD;
      ceQ      <= ceD;
      addrErrQ <= addrErrD;
      updateQ  <= (stateD == StUpdate);
      doneQ    <= (stateD == StDone);
      busyQ    <= (stateD != StIdle);
    end
  end

  assign thresh_o      = threshQ;
  assign thresh_ce_o   = ceQ;
  assign addr_err_o    = addrErrQ;
  assign update_o      = updateQ;
  assign commit_done_o = doneQ;
  assign busy_o        = busyQ;

endmodule

// File: tb/tb_beam_thresh_loader.sv
// Directed bench for beam_thresh_loader: writes, commits, range errors and reset abort.
module tb_beam_thresh_loader;

  localparam int unsigned NBEAMS    = 48;
  localparam int unsigned ADDR_BITS = 6;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [17:0]          threshDat = '0;
  logic [ADDR_BITS-1:0] threshAddr = '0;
  logic                 threshValid = 1'b0;
  logic                 threshReady;
  logic                 commit = 1'b0;
  logic [17:0]          threshOut;
  logic [NBEAMS-1:0]    threshCe;
  logic                 update, commitDone, addrErr, busy;

  int checks = 0;
  int errors = 0;
  int updCnt;
  int rdyLowCnt;

  beam_thresh_loader #(.NBEAMS(NBEAMS), .ADDR_BITS(ADDR_BITS)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .thresh_dat_i  (threshDat),
    .thresh_addr_i (threshAddr),
    .thresh_valid_i(threshValid),
    .thresh_ready_o(threshReady),
    .commit_i      (commit),
    .thresh_o      (threshOut),
    .thresh_ce_o   (threshCe),
    .update_o      (update),
    .commit_done_o (commitDone),
    .addr_err_o    (addrErr),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] bit64(input int k);
    logic [63:0] one;
    one = 64'd1;
    return one << k;
  endfunction

  initial begin
    // Reset state, with a write already waiting on the inputs.
    threshValid = 1'b1;
    threshAddr  = 6'd5;
    threshDat   = 18'h13880;
    tick();
    tick();
    checkVal("rst_thresh", 64'(threshOut), 64'h0);
    checkVal("rst_ce", 64'(threshCe), 64'h0);
    checkVal("rst_flags", {59'h0, update, commitDone, addrErr, busy, threshReady}, 64'h0);
    rst = 1'b0;
    #1;
    checkVal("rel_ready", 64'(threshReady), 64'h1);

    // First edge after release accepts the write.
    tick();
    threshValid = 1'b0;
    checkVal("w5_thresh", 64'(threshOut), 64'h13880);
    checkVal("w5_ce", 64'(threshCe), bit64(5));
    checkVal("w5_update", 64'(update), 64'h0);
    tick();
    checkVal("w5_ce_clr", 64'(threshCe), 64'h0);
    checkVal("w5_hold", 64'(threshOut), 64'h13880);

    // Back-to-back writes to 0, 1, 47 then commit.
    threshValid = 1'b1; threshAddr = 6'd0;  threshDat = 18'h00111;
    tick();
    checkVal("b2b_ce0", 64'(threshCe), bit64(0));
    checkVal("b2b_d0", 64'(threshOut), 64'h00111);
    threshAddr = 6'd1; threshDat = 18'h00222;
    tick();
    checkVal("b2b_ce1", 64'(threshCe), bit64(1));
    checkVal("b2b_d1", 64'(threshOut), 64'h00222);
    threshAddr = 6'd47; threshDat = 18'h2AAAA;
    tick();
    checkVal("b2b_ce47", 64'(threshCe), bit64(47));
    checkVal("b2b_d47", 64'(threshOut), 64'h2AAAA);
    threshValid = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    checkVal("cm_drain", {60'h0, busy, threshReady, update, commitDone}, {60'h0, 4'b1000});
    checkVal("cm_drain_ce", 64'(threshCe), 64'h0);
    tick();
    checkVal("cm_update", {60'h0, busy, threshReady, update, commitDone}, {60'h0, 4'b1010});
    tick();
    checkVal("cm_done", {60'h0, busy, threshReady, update, commitDone}, {60'h0, 4'b1001});
    tick();
    checkVal("cm_idle", {60'h0, busy, threshReady, update, commitDone}, {60'h0, 4'b0100});

    // Same-edge write and commit: strobe lands in DRAIN, before update.
    threshValid = 1'b1; threshAddr = 6'd10; threshDat = 18'h3FFFF;
    commit = 1'b1;
    tick();
    threshValid = 1'b0; commit = 1'b0;
    checkVal("sw_ce10", 64'(threshCe), bit64(10));
    checkVal("sw_d", 64'(threshOut), 64'h3FFFF);
    checkVal("sw_noupd", 64'(update), 64'h0);
    tick();
    checkVal("sw_upd", 64'(update), 64'h1);
    checkVal("sw_ce_clr", 64'(threshCe), 64'h0);
    tick();
    tick();

    // Out-of-range address.
    threshValid = 1'b1; threshAddr = 6'd50; threshDat = 18'h12345;
    tick();
    threshValid = 1'b0;
    checkVal("oor_err", 64'(addrErr), 64'h1);
    checkVal("oor_ce", 64'(threshCe), 64'h0);
    checkVal("oor_hold", 64'(threshOut), 64'h3FFFF);
    tick();
    checkVal("oor_err_clr", 64'(addrErr), 64'h0);

    // Commit held four edges; a write raised during DRAIN waits until IDLE.
    updCnt = 0;
    rdyLowCnt = 0;
    commit = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      updCnt += int'(update);
      rdyLowCnt += int'(!threshReady);
      if (c == 1) begin
        threshValid = 1'b1; threshAddr = 6'd3; threshDat = 18'h00ABC;
      end
      if (c == 2) checkVal("hold_pend_ce", 64'(threshCe), 64'h0);
      if (c == 4) begin
        commit = 1'b0;
        checkVal("hold_ready", 64'(threshReady), 64'h1);
      end
      if (c == 5) begin
        threshValid = 1'b0;
        checkVal("hold_acc_ce", 64'(threshCe), bit64(3));
        checkVal("hold_acc_d", 64'(threshOut), 64'h00ABC);
        checkVal("hold_no_recommit", 64'(busy), 64'h0);
      end
    end
    checkVal("hold_upd_cnt", 64'(updCnt), 64'd1);
    checkVal("hold_rdy_low", 64'(rdyLowCnt), 64'd3);

    // Reset during DRAIN aborts the commit.
    commit = 1'b1;
    tick();
    commit = 1'b0;
    checkVal("ab_drain", 64'(busy), 64'h1);
    rst = 1'b1;
    #1;
    checkVal("ab_flags", {59'h0, update, commitDone, addrErr, busy, threshReady}, 64'h0);
    checkVal("ab_thresh", 64'(threshOut), 64'h0);
    checkVal("ab_ce", 64'(threshCe), 64'h0);
    updCnt = 0;
    tick();
    updCnt += int'(update) + int'(commitDone);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      updCnt += int'(update) + int'(commitDone);
    end
    checkVal("ab_no_update", 64'(updCnt), 64'd0);
    checkVal("ab_idle", {62'h0, busy, threshReady}, 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/beam_thresh_loader.md
BEAM_THRESH_LOADER -- requirements
Module: beam_thresh_loader

Interface
REQ-001 Parameter NBEAMS, default 48, number of beams thresholded (even; NBEAMS/2 dual-beam DSP pairs).
REQ-002 Parameter ADDR_BITS, default 6, threshold address width; 2^ADDR_BITS >= NBEAMS.
REQ-003 clk_i  input  1  sole clock, all logic rising-edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 thresh_dat_i  input  18  threshold value to load.
REQ-006 thresh_addr_i  input  ADDR_BITS  target beam index.
REQ-007 thresh_valid_i  input  1  write request.
REQ-008 thresh_ready_o  output  1  write accepted when valid & ready.
REQ-009 commit_i  input  1  request common update of all staged thresholds.
REQ-010 thresh_o  output  18  threshold bus broadcast to all dual-beam DSPs.
REQ-011 thresh_ce_o  output  NBEAMS  per-beam load strobe; bit 2k -> pair k thresh_ce_i[0] (beam B), bit 2k+1 -> pair k thresh_ce_i[1] (beam A).
REQ-012 update_o  output  1  common update strobe to all pairs' update_i.
REQ-013 commit_done_o  output  1  one-cycle pulse, commit finished.
REQ-014 addr_err_o  output  1  one-cycle pulse, out-of-range write dropped.
REQ-015 busy_o  output  1  high whenever FSM not IDLE.

Function
REQ-016 FSM states IDLE, DRAIN, UPDATE, DONE; thresh_ready_o = (state==IDLE) & ~rst_i.
REQ-017 Accepted write with addr < NBEAMS at edge n: cycle n+1 thresh_o = thresh_dat_i, thresh_ce_o one-hot at addr, for exactly one cycle.
REQ-018 Accepted write with addr >= NBEAMS: thresh_ce_o stays 0, addr_err_o high cycle n+1, thresh_o unchanged.
REQ-019 thresh_o holds last loaded value between writes; thresh_ce_o all-zero when no write accepted previous cycle.
REQ-020 Back-to-back writes accepted every cycle while IDLE; each yields its own single-cycle strobe.
REQ-021 IDLE with commit_i high at edge n -> DRAIN at n+1, UPDATE at n+2, DONE at n+3, IDLE at n+4.
REQ-022 update_o high exactly during UPDATE (cycle n+2); commit_done_o high exactly during DONE (cycle n+3).
REQ-023 DRAIN guarantees the last thresh_ce_o strobe precedes update_o by at least one cycle.
REQ-024 Write and commit_i both in IDLE same edge: write accepted, its strobe at n+1, included in the n+2 update.
REQ-025 commit_i while not IDLE ignored; no queued commit, no extra update_o.
REQ-026 thresh_valid_i while not IDLE not accepted; request stays pending on input until IDLE.
REQ-027 Outputs registered; no combinational path input -> output except thresh_ready_o from state/reset.

Reset
REQ-028 While rst_i high: state IDLE, thresh_o = 0, thresh_ce_o = 0, update_o = 0, commit_done_o = 0, addr_err_o = 0, busy_o = 0, thresh_ready_o = 0.
REQ-029 rst_i asserted mid-commit aborts immediately: no update_o or commit_done_o after reset, IDLE on release.
REQ-030 First write accepted on first rising edge after rst_i release with valid high.

Verification
REQ-031 Write addr 5 data 0x13880 -> next cycle thresh_o=0x13880, thresh_ce_o=1<<5 for one cycle, no update_o.
REQ-032 Writes addr 0,1,47 back-to-back then commit_i -> three one-hot strobes in order, update_o 2 cycles after commit, commit_done_o 1 cycle later.
REQ-033 Same-edge write addr 10 data 0x3FFFF + commit_i -> ce bit 10 at n+1, update_o at n+2.
REQ-034 Write addr 50 (NBEAMS=48) -> addr_err_o one pulse, thresh_ce_o all zero, thresh_o unchanged.
REQ-035 commit_i held 4 cycles -> exactly one update_o, thresh_ready_o low 3 cycles (DRAIN..DONE), pending write accepted on return to IDLE.
REQ-036 rst_i asserted during DRAIN -> all outputs 0 immediately, no update_o ever produced for that commit.
